// File: rtl/multicycle_control_if.sv
// Control bundle between the multicycle RV32I sequencer and its shared datapath.
// master = controller (drives selects/enables), slave = datapath (drives instruction fields and zero).
interface multicycle_control_if;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       funct7_5;
  logic       zero;

  logic       PCWrite;
  logic       AdrSrc;
  logic       MemWrite;
  logic       IRWrite;
  logic       RegWrite;
  logic [1:0] ResultSrc;
  logic [1:0] ALUSrcA;
  logic [1:0] ALUSrcB;
  logic [2:0] alu_control;
  logic [1:0] immSrc;
  logic       illegal;
  logic [3:0] state_dbg;

  modport master (
    input  op, funct3, funct7_5, zero,
    output PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc,
           ALUSrcA, ALUSrcB, alu_control, immSrc, illegal, state_dbg
  );

  modport slave (
    output op, funct3, funct7_5, zero,
    input  PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc,
           ALUSrcA, ALUSrcB, alu_control, immSrc, illegal, state_dbg
  );
endinterface

// File: rtl/multicycle_control.sv
// Moore sequencer for the multicycle RV32I core: FETCH/DECODE/EXECUTE/MEM/WB over one ALU and one memory.
// Outputs follow the state register; PCWrite also follows zero, alu_control/immSrc follow the instruction fields.
module multicycle_control (
  input  logic                 clk,
  input  logic                 reset,
  multicycle_control_if.master ctl
);

  localparam logic [3:0] S_FETCH    = 4'd0;
  localparam logic [3:0] S_DECODE   = 4'd1;
  localparam logic [3:0] S_MEMADR   = 4'd2;
  localparam logic [3:0] S_MEMREAD  = 4'd3;
  localparam logic [3:0] S_MEMWB    = 4'd4;
  localparam logic [3:0] S_MEMWRITE = 4'd5;
  localparam logic [3:0] S_EXECUTER = 4'd6;
  localparam logic [3:0] S_EXECUTEI = 4'd7;
  localparam logic [3:0] S_ALUWB    = 4'd8;
  localparam logic [3:0] S_BEQ      = 4'd9;
  localparam logic [3:0] S_JAL      = 4'd10;

  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_RTYP = 7'b0110011;
  localparam logic [6:0] OP_ITYP = 7'b0010011;
  localparam logic [6:0] OP_BEQ  = 7'b1100011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;

  localparam logic [1:0] ALUOP_ADD   = 2'd0;
  localparam logic [1:0] ALUOP_SUB   = 2'd1;
  localparam logic [1:0] ALUOP_FUNCT = 2'd2;

  logic [3:0] state;
  logic [3:0] state_nxt;

  logic       pc_update;
  logic       branch;
  logic [1:0] alu_op;
  logic       adr_src;
  logic       mem_write;
  logic       ir_write;
  logic       reg_write;
  logic [1:0] result_src;
  logic [1:0] alu_src_a;
  logic [1:0] alu_src_b;
  logic       illegal_op;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_FETCH;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = S_FETCH;
    case (state)
      S_FETCH: state_nxt = S_DECODE;
      S_DECODE: begin
        case (ctl.op)
          OP_LW, OP_SW: state_nxt = S_MEMADR;
          OP_RTYP:      state_nxt = S_EXECUTER;
          OP_ITYP:      state_nxt = S_EXECUTEI;
          OP_BEQ:       state_nxt = S_BEQ;
          OP_JAL:       state_nxt = S_JAL;
          default:      state_nxt = S_FETCH;
        endcase
      end
      S_MEMADR:   state_nxt = (ctl.op == OP_SW) ? S_MEMWRITE : S_MEMREAD;
      S_MEMREAD:  state_nxt = S_MEMWB;
      S_MEMWB:    state_nxt = S_FETCH;
      S_MEMWRITE: state_nxt = S_FETCH;
      S_EXECUTER: state_nxt = S_ALUWB;
      S_EXECUTEI: state_nxt = S_ALUWB;
      S_ALUWB:    state_nxt = S_FETCH;
      S_BEQ:      state_nxt = S_FETCH;
      S_JAL:      state_nxt = S_ALUWB;
      default:    state_nxt = S_FETCH;
    endcase
  end

  // DECODE recognises the opcode here so the illegal pulse lines up with the FETCH return
  always_comb begin
    illegal_op = 1'b1;
    case (ctl.op)
      OP_LW, OP_SW, OP_RTYP, OP_ITYP, OP_BEQ, OP_JAL: illegal_op = 1'b0;
      default:                                         illegal_op = 1'b1;
    endcase
  end

  always_comb begin
    pc_update  = 1'b0;
    branch     = 1'b0;
    alu_op     = ALUOP_ADD;
    adr_src    = 1'b0;
    mem_write  = 1'b0;
    ir_write   = 1'b0;
    reg_write  = 1'b0;
    result_src = 2'b00;
    alu_src_a  = 2'b00;
    alu_src_b  = 2'b00;
    case (state)
      S_FETCH: begin
        ir_write   = 1'b1;
        alu_src_b  = 2'b10;
        result_src = 2'b10;
        pc_update  = 1'b1;
      end
      S_DECODE: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b01;
      end
      S_MEMADR: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
      end
      S_MEMREAD: begin
        adr_src = 1'b1;
      end
      S_MEMWB: begin
        result_src = 2'b01;
        reg_write  = 1'b1;
      end
      S_MEMWRITE: begin
        adr_src   = 1'b1;
        mem_write = 1'b1;
      end
      S_EXECUTER: begin
        alu_src_a = 2'b10;
        alu_op    = ALUOP_FUNCT;
      end
      S_EXECUTEI: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
        alu_op    = ALUOP_FUNCT;
      end
      S_ALUWB: begin
        reg_write = 1'b1;
      end
      S_BEQ: begin
        alu_src_a = 2'b10;
        alu_op    = ALUOP_SUB;
        branch    = 1'b1;
      end
      S_JAL: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b10;
        pc_update = 1'b1;
      end
      default: begin
        pc_update = 1'b0;
      end
    endcase
  end

  // op[5] separates R-type from I-type, so addi with imm bit 30 set never subtracts
  always_comb begin
    ctl.alu_control = 3'b000;
    case (alu_op)
      ALUOP_SUB: ctl.alu_control = 3'b001;
      ALUOP_FUNCT: begin
        case (ctl.funct3)
          3'b000:  ctl.alu_control = (ctl.op[5] & ctl.funct7_5) ? 3'b001 : 3'b000;
          3'b010:  ctl.alu_control = 3'b101;
          3'b110:  ctl.alu_control = 3'b011;
          3'b111:  ctl.alu_control = 3'b010;
          default: ctl.alu_control = 3'b000;
        endcase
      end
      default: ctl.alu_control = 3'b000;
    endcase
  end

  always_comb begin
    ctl.immSrc = 2'b00;
    case (ctl.op)
      OP_SW:   ctl.immSrc = 2'b01;
      OP_BEQ:  ctl.immSrc = 2'b10;
      OP_JAL:  ctl.immSrc = 2'b11;
      default: ctl.immSrc = 2'b00;
    endcase
  end

  // Write enables are gated by reset directly so nothing commits while reset is held
  assign ctl.PCWrite   = ~reset & (pc_update | (branch & ctl.zero));
  assign ctl.MemWrite  = ~reset & mem_write;
  assign ctl.IRWrite   = ~reset & ir_write;
  assign ctl.RegWrite  = ~reset & reg_write;
  assign ctl.illegal   = ~reset & (state == S_DECODE) & illegal_op;

  assign ctl.AdrSrc    = adr_src;
  assign ctl.ResultSrc = result_src;
  assign ctl.ALUSrcA   = alu_src_a;
  assign ctl.ALUSrcB   = alu_src_b;
  assign ctl.state_dbg = state;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: walks each instruction class through its state sequence.
module tb_multicycle_control;
  logic clk;
  logic reset;
  int   checks;
  int   failures;

  multicycle_control_if ctl ();

  multicycle_control dut (
    .clk   (clk),
    .reset (reset),
    .ctl   (ctl.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  function automatic logic [7:0] we();
    return {4'd0, ctl.PCWrite, ctl.MemWrite, ctl.IRWrite, ctl.RegWrite};
  endfunction

  initial begin
    checks = 0;
    failures = 0;
    reset = 1'b1;
    ctl.op = 7'b0000011;
    ctl.funct3 = 3'b010;
    ctl.funct7_5 = 1'b0;
    ctl.zero = 1'b0;
    step();
    step();
    chk("rst_state", 8'(ctl.state_dbg), 8'd0);
    chk("rst_we", we(), 8'h0);
    chk("rst_illegal", 8'(ctl.illegal), 8'd0);

    // lw x5,8(x1)
    reset = 1'b0;
    #1;
    chk("lw_fetch_state", 8'(ctl.state_dbg), 8'd0);
    chk("lw_fetch_we", we(), 8'b1010);
    chk("lw_fetch_srcb", 8'(ctl.ALUSrcB), 8'd2);
    chk("lw_fetch_res", 8'(ctl.ResultSrc), 8'd2);
    chk("lw_fetch_adr", 8'(ctl.AdrSrc), 8'd0);
    step();
    chk("lw_dec_state", 8'(ctl.state_dbg), 8'd1);
    chk("lw_dec_srca", 8'(ctl.ALUSrcA), 8'd1);
    chk("lw_dec_srcb", 8'(ctl.ALUSrcB), 8'd1);
    chk("lw_dec_we", we(), 8'h0);
    step();
    chk("lw_madr_state", 8'(ctl.state_dbg), 8'd2);
    chk("lw_madr_srca", 8'(ctl.ALUSrcA), 8'd2);
    chk("lw_madr_alu", 8'(ctl.alu_control), 8'd0);
    step();
    chk("lw_mrd_state", 8'(ctl.state_dbg), 8'd3);
    chk("lw_mrd_adr", 8'(ctl.AdrSrc), 8'd1);
    chk("lw_mrd_res", 8'(ctl.ResultSrc), 8'd0);
    step();
    chk("lw_mwb_state", 8'(ctl.state_dbg), 8'd4);
    chk("lw_mwb_we", we(), 8'b0001);
    chk("lw_mwb_res", 8'(ctl.ResultSrc), 8'd1);
    chk("lw_imm", 8'(ctl.immSrc), 8'd0);
    step();
    chk("lw_end_state", 8'(ctl.state_dbg), 8'd0);

    // sw, reset asserted during MEMWRITE
    ctl.op = 7'b0100011;
    step();
    chk("sw_dec_imm", 8'(ctl.immSrc), 8'd1);
    step();
    chk("sw_madr_state", 8'(ctl.state_dbg), 8'd2);
    step();
    chk("sw_mwr_state", 8'(ctl.state_dbg), 8'd5);
    chk("sw_mwr_we", we(), 8'b0100);
    chk("sw_mwr_adr", 8'(ctl.AdrSrc), 8'd1);
    reset = 1'b1;
    #1;
    chk("sw_rst_memwrite", 8'(ctl.MemWrite), 8'd0);
    chk("sw_rst_async_state", 8'(ctl.state_dbg), 8'd0);
    step();
    chk("sw_rst_state", 8'(ctl.state_dbg), 8'd0);
    chk("sw_rst_we", we(), 8'h0);
    reset = 1'b0;
    #1;
    chk("rel_fetch_we", we(), 8'b1010);
    chk("rel_fetch_srcb", 8'(ctl.ALUSrcB), 8'd2);
    chk("rel_fetch_res", 8'(ctl.ResultSrc), 8'd2);

    // R-type sub
    ctl.op = 7'b0110011;
    ctl.funct3 = 3'b000;
    ctl.funct7_5 = 1'b1;
    step();
    chk("sub_dec_state", 8'(ctl.state_dbg), 8'd1);
    step();
    chk("sub_exr_state", 8'(ctl.state_dbg), 8'd6);
    chk("sub_exr_alu", 8'(ctl.alu_control), 8'd1);
    chk("sub_exr_srca", 8'(ctl.ALUSrcA), 8'd2);
    chk("sub_exr_srcb", 8'(ctl.ALUSrcB), 8'd0);
    ctl.funct3 = 3'b010;
    #1;
    chk("slt_exr_alu", 8'(ctl.alu_control), 8'd5);
    ctl.funct3 = 3'b110;
    #1;
    chk("or_exr_alu", 8'(ctl.alu_control), 8'd3);
    step();
    chk("sub_wb_state", 8'(ctl.state_dbg), 8'd8);
    chk("sub_wb_we", we(), 8'b0001);
    chk("sub_wb_res", 8'(ctl.ResultSrc), 8'd0);
    step();
    chk("sub_end_state", 8'(ctl.state_dbg), 8'd0);

    // addi with funct7_5=1 still adds
    ctl.op = 7'b0010011;
    ctl.funct3 = 3'b000;
    ctl.funct7_5 = 1'b1;
    step();
    step();
    chk("addi_exi_state", 8'(ctl.state_dbg), 8'd7);
    chk("addi_exi_alu", 8'(ctl.alu_control), 8'd0);
    chk("addi_exi_srcb", 8'(ctl.ALUSrcB), 8'd1);
    ctl.funct3 = 3'b111;
    #1;
    chk("andi_exi_alu", 8'(ctl.alu_control), 8'd2);
    step();
    chk("addi_wb_state", 8'(ctl.state_dbg), 8'd8);
    step();
    chk("addi_end_state", 8'(ctl.state_dbg), 8'd0);

    // beq: taken then not-taken in the same BEQ cycle
    ctl.op = 7'b1100011;
    ctl.funct3 = 3'b000;
    ctl.funct7_5 = 1'b0;
    step();
    chk("beq_dec_imm", 8'(ctl.immSrc), 8'd2);
    ctl.zero = 1'b1;
    step();
    chk("beq_state", 8'(ctl.state_dbg), 8'd9);
    chk("beq_z1_pcw", 8'(ctl.PCWrite), 8'd1);
    chk("beq_alu", 8'(ctl.alu_control), 8'd1);
    ctl.zero = 1'b0;
    #1;
    chk("beq_z0_pcw", 8'(ctl.PCWrite), 8'd0);
    step();
    chk("beq_end_state", 8'(ctl.state_dbg), 8'd0);

    // jal
    ctl.op = 7'b1101111;
    step();
    chk("jal_dec_state", 8'(ctl.state_dbg), 8'd1);
    step();
    chk("jal_state", 8'(ctl.state_dbg), 8'd10);
    chk("jal_pcw", 8'(ctl.PCWrite), 8'd1);
    chk("jal_imm", 8'(ctl.immSrc), 8'd3);
    chk("jal_srca", 8'(ctl.ALUSrcA), 8'd1);
    chk("jal_srcb", 8'(ctl.ALUSrcB), 8'd2);
    step();
    chk("jal_wb_state", 8'(ctl.state_dbg), 8'd8);
    chk("jal_wb_we", we(), 8'b0001);
    step();
    chk("jal_end_state", 8'(ctl.state_dbg), 8'd0);

    // illegal opcode
    ctl.op = 7'b1111111;
    chk("ill_fetch_illegal", 8'(ctl.illegal), 8'd0);
    step();
    chk("ill_dec_state", 8'(ctl.state_dbg), 8'd1);
    chk("ill_dec_illegal", 8'(ctl.illegal), 8'd1);
    chk("ill_dec_we", we(), 8'h0);
    step();
    chk("ill_end_state", 8'(ctl.state_dbg), 8'd0);
    chk("ill_end_illegal", 8'(ctl.illegal), 8'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
